// File: rtl/mul5_pipe.sv
// mul5_pipe: registered 5x5 unsigned array multiplier (carry-save rows + final ripple adder), 2-edge latency
module mul5_pipe (
  input  logic       clk,
  input  logic       reset,
  input  logic [4:0] a,
  input  logic [4:0] b,
  output logic [9:0] s
);
  logic [4:0] a_r, b_r;
  logic [4:0] sm [5];
  logic [4:0] cy [5];
  logic [9:0] p;
  always_comb begin
    logic x, y, z, c;
    logic [4:0] nxt;
    p = '0;
    sm[0] = a_r & {5{b_r[0]}};
    cy[0] = '0;
    p[0] = sm[0][0];
    for (int i = 1; i < 5; i++) begin
      nxt = {1'b0, sm[i-1][4:1]};
      for (int j = 0; j < 5; j++) begin
        x = a_r[j] & b_r[i];
        y = nxt[j];
        z = cy[i-1][j];
        sm[i][j] = x ^ y ^ z;
        cy[i][j] = (x & y) | (x & z) | (y & z);
      end
      p[i] = sm[i][0];
    end
    // row 4 leaves sums at weights 5..8 and carries at 5..9 for the ripple stage
    nxt = {1'b0, sm[4][4:1]};
    c = 1'b0;
    for (int k = 0; k < 4; k++) begin
      p[5+k] = nxt[k] ^ cy[4][k] ^ c;
      c = (nxt[k] & cy[4][k]) | (nxt[k] & c) | (cy[4][k] & c);
    end
    p[9] = cy[4][4] ^ c;
  end
  always_ff @(posedge clk or negedge reset)
    if (!reset) begin
      a_r <= '0;
      b_r <= '0;
      s   <= '0;
    end else begin
      a_r <= a;
      b_r <= b;
      s   <= p;
    end
endmodule

// File: tb/tb_mul5_pipe.sv
// tb_mul5_pipe: random and directed checks of mul5_pipe against a one-deep product queue model
module tb_mul5_pipe;
  logic clk = 0, reset = 0;
  logic [4:0] a = 0, b = 0;
  logic [9:0] s;
  int n_cmp = 0, n_bad = 0;
  int pa = 0, pb = 0;
  bit have = 0;

  mul5_pipe dut (.clk(clk), .reset(reset), .a(a), .b(b), .s(s));

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [9:0] got, input logic [9:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d at %0t", tag, got, exp, $time);
    end
  endtask

  // operands captured at one edge show up as their product after the next edge
  task automatic step(input string tag, input int x, input int y);
    int e;
    a = 5'(x);
    b = 5'(y);
    @(posedge clk);
    #1;
    e = have ? pa * pb : 0;
    pa = x;
    pb = y;
    have = 1;
    chk(tag, s, 10'(e));
  endtask

  task automatic pulse_reset(input string tag);
    #2 reset = 0;
    #1 chk({tag, "_async"}, s, 10'd0);
    have = 0;
    @(posedge clk);
    #1 chk({tag, "_hold"}, s, 10'd0);
    @(negedge clk);
    reset = 1;
  endtask

  initial begin
    int ta [4] = '{31, 0, 31, 16};
    int tb [4] = '{31, 31, 1, 16};
    a = 5;
    b = 3;
    repeat (3) begin
      @(posedge clk);
      #1 chk("in_reset", s, 10'd0);
    end
    @(negedge clk);
    reset = 1;
    step("first_edge", 5, 3);
    step("p15", 7, 9);
    chk("p15_val", s, 10'd15);
    step("p63", 7, 9);
    chk("p63_val", s, 10'd63);
    for (int i = 0; i < 4; i++) step("bound", ta[i], tb[i]);
    step("bound_last", 0, 0);
    pulse_reset("mid_rst");
    for (int i = 0; i < 1000; i++) step("stream", $urandom_range(31), $urandom_range(31));
    pulse_reset("stream_rst");
    for (int i = 0; i < 50; i++) step("post_rst", $urandom_range(31), $urandom_range(31));
    for (int x = 0; x < 32; x++)
      for (int y = 0; y < 32; y++) step("sweep", x, y);
    step("sweep_last", 0, 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
